jt12_lfo: RTL and testbench

- Low-frequency oscillator for the YM2612-compatible core.
- Runs a 7-bit LFO phase counter, advanced once every N output samples, with N chosen from 8 rate settings.
- Produces the tremolo (AM) word consumed by the envelope generator's AM input (7 bits, scaled there by AMS).
- Produces the vibrato (PM) index consumed by the phase generator.
- Sits upstream of the envelope stage; shares its clk/clk_en domain and its once-per-sample `zero` strobe.

---
 rtl/jt12_lfo.sv | 96 +++++++++
 tb/tb_jt12_lfo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/jt12_lfo.sv
// YM2612 low-frequency oscillator: 7-bit phase counter producing tremolo (am) and vibrato (pm) words.
// Optional JT12_LFO_TEST_EN adds input test_lfo, which forces an LFO step on every sample tick.
module jt12_lfo #(
    parameter int DIVW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            zero,
    input  logic            lfo_en,
    input  logic [2:0]      lfo_freq,
`ifdef JT12_LFO_TEST_EN
    input  logic            test_lfo,
`endif
    output logic [6:0]      am,
    output logic [4:0]      pm,
    output logic [6:0]      lfo_cnt,
    output logic            lfo_step
);

    logic [DIVW-1:0] r_div;
    logic [DIVW-1:0] w_lim;
    logic [DIVW-1:0] w_div_next;
    logic [6:0]      r_cnt;
    logic [6:0]      w_cnt_next;
    logic            r_step;
    logic            w_step_next;
    logic [6:0]      r_am;
    logic [4:0]      r_pm;
    logic [5:0]      w_tri;
    logic            w_test;

`ifdef JT12_LFO_TEST_EN
    assign w_test = test_lfo;
`else
    assign w_test = 1'b0;
`endif

    // Terminal divider value is period-1, in output samples per LFO step
    always_comb begin
        w_lim = DIVW'(107);
        case (lfo_freq)
            3'd0:    w_lim = DIVW'(107);
            3'd1:    w_lim = DIVW'(76);
            3'd2:    w_lim = DIVW'(70);
            3'd3:    w_lim = DIVW'(66);
            3'd4:    w_lim = DIVW'(61);
            3'd5:    w_lim = DIVW'(43);
            3'd6:    w_lim = DIVW'(7);
            default: w_lim = DIVW'(4);
        endcase
    end

    // >= rather than == so a lowered rate mid-count steps on the next tick instead of locking up
    always_comb begin
        w_div_next  = r_div;
        w_cnt_next  = r_cnt;
        w_step_next = 1'b0;
        if (!lfo_en) begin
            w_div_next = '0;
            w_cnt_next = '0;
        end else if (zero) begin
            if (w_test || (r_div >= w_lim)) begin
                w_div_next  = '0;
                w_cnt_next  = r_cnt + 7'd1;
                w_step_next = 1'b1;
            end else begin
                w_div_next = r_div + DIVW'(1);
            end
        end
        w_tri = w_cnt_next[6] ? ~w_cnt_next[5:0] : w_cnt_next[5:0];
    end

    // am/pm derive from the next phase so they always match lfo_cnt; a disabled LFO yields phase 0, hence am=pm=0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_cnt  <= '0;
            r_step <= 1'b0;
            r_am   <= '0;
            r_pm   <= '0;
        end else if (clk_en) begin
            r_div  <= w_div_next;
            r_cnt  <= w_cnt_next;
            r_step <= w_step_next;
            r_am   <= {w_tri, 1'b0};
            r_pm   <= w_cnt_next[6:2];
        end
    end

    assign am       = r_am;
    assign pm       = r_pm;
    assign lfo_cnt  = r_cnt;
    assign lfo_step = r_step;

endmodule

// File: tb/tb_jt12_lfo.sv
// Directed self-checking bench for jt12_lfo; define JT12_LFO_TEST_EN to also exercise test_lfo.
module tb_jt12_lfo;

    logic       clk;
    logic       rst_n;
    logic       clk_en;
    logic       zero;
    logic       lfo_en;
    logic [2:0] lfo_freq;
`ifdef JT12_LFO_TEST_EN
    logic       test_lfo;
`endif
    logic [6:0] am;
    logic [4:0] pm;
    logic [6:0] lfo_cnt;
    logic       lfo_step;

    int errors = 0;
    int checks = 0;

    jt12_lfo #(.DIVW(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clk_en   (clk_en),
        .zero     (zero),
        .lfo_en   (lfo_en),
        .lfo_freq (lfo_freq),
`ifdef JT12_LFO_TEST_EN
        .test_lfo (test_lfo),
`endif
        .am       (am),
        .pm       (pm),
        .lfo_cnt  (lfo_cnt),
        .lfo_step (lfo_step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the following falling edge
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            clk_en = 1'b1;
            zero   = 1'b1;
            @(negedge clk);
        end
        zero = 1'b0;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        clk_en = 1'b1;
        zero   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (am !== 7'd0)      begin errors++; $display("[TB] FAIL reset_am: got %0d expected 0", am); end
        checks++; if (pm !== 5'd0)      begin errors++; $display("[TB] FAIL reset_pm: got %0d expected 0", pm); end
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", lfo_cnt); end
        checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL reset_step: got %0b expected 0", lfo_step); end
    endtask

    task automatic test_fastest();
        do_reset();
        lfo_en   = 1'b1;
        lfo_freq = 3'd7;
        tick(4);
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL fast_cnt4: got %0d expected 0", lfo_cnt); end
        checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL fast_step4: got %0b expected 0", lfo_step); end
        tick(1);
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL fast_cnt5: got %0d expected 1", lfo_cnt); end
        checks++; if (lfo_step !== 1'b1) begin errors++; $display("[TB] FAIL fast_step5: got %0b expected 1", lfo_step); end
        @(negedge clk);
        checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL fast_step_clear: got %0b expected 0", lfo_step); end
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL fast_idle_cnt: got %0d expected 1", lfo_cnt); end
        tick(315);
        checks++; if (lfo_cnt !== 7'd64) begin errors++; $display("[TB] FAIL fast_cnt320: got %0d expected 64", lfo_cnt); end
        checks++; if (am !== 7'd126)     begin errors++; $display("[TB] FAIL fast_am320: got %0d expected 126", am); end
        checks++; if (pm !== 5'd16)      begin errors++; $display("[TB] FAIL fast_pm320: got %0d expected 16", pm); end
    endtask

    task automatic test_triangle();
        int expAm;
        logic [6:0] expCnt;
        do_reset();
        lfo_en   = 1'b1;
        lfo_freq = 3'd6;
        @(negedge clk);
        checks++; if (am !== 7'd0) begin errors++; $display("[TB] FAIL tri_am0: got %0d expected 0", am); end
        for (int s = 1; s <= 128; s++) begin
            tick(7);
            checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL tri_early_step at step %0d: got %0b expected 0", s, lfo_step); end
            tick(1);
            expCnt = 7'(s);
            checks++; if (lfo_cnt !== expCnt) begin errors++; $display("[TB] FAIL tri_cnt: got %0d expected %0d", lfo_cnt, expCnt); end
            checks++; if (lfo_step !== 1'b1) begin errors++; $display("[TB] FAIL tri_step at step %0d: got %0b expected 1", s, lfo_step); end
            expAm = -1;
            case (s)
                31:  expAm = 62;
                63:  expAm = 126;
                64:  expAm = 126;
                100: expAm = 54;
                127: expAm = 0;
                128: expAm = 0;
                default: expAm = -1;
            endcase
            if (expAm >= 0) begin
                checks++; if (am !== 7'(expAm)) begin errors++; $display("[TB] FAIL tri_am at cnt %0d: got %0d expected %0d", expCnt, am, expAm); end
            end
            if (s == 100) begin
                checks++; if (pm !== 5'd25) begin errors++; $display("[TB] FAIL tri_pm100: got %0d expected 25", pm); end
            end
        end
    endtask

    task automatic test_rate_change();
        do_reset();
        lfo_en   = 1'b1;
        lfo_freq = 3'd0;
        tick(90);
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL rate_cnt90: got %0d expected 0", lfo_cnt); end
        lfo_freq = 3'd5;
        tick(1);
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL rate_switch_cnt: got %0d expected 1", lfo_cnt); end
        checks++; if (lfo_step !== 1'b1) begin errors++; $display("[TB] FAIL rate_switch_step: got %0b expected 1", lfo_step); end
        tick(43);
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL rate_cnt43: got %0d expected 1", lfo_cnt); end
        tick(1);
        checks++; if (lfo_cnt !== 7'd2) begin errors++; $display("[TB] FAIL rate_cnt44: got %0d expected 2", lfo_cnt); end
    endtask

    task automatic test_disable();
        do_reset();
        lfo_en   = 1'b1;
        lfo_freq = 3'd7;
        tick(200);
        checks++; if (lfo_cnt !== 7'd40) begin errors++; $display("[TB] FAIL dis_cnt40: got %0d expected 40", lfo_cnt); end
        checks++; if (am !== 7'd80)      begin errors++; $display("[TB] FAIL dis_am40: got %0d expected 80", am); end
        checks++; if (pm !== 5'd10)      begin errors++; $display("[TB] FAIL dis_pm40: got %0d expected 10", pm); end
        lfo_en = 1'b0;
        tick(1);
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL dis_cnt: got %0d expected 0", lfo_cnt); end
        checks++; if (am !== 7'd0)      begin errors++; $display("[TB] FAIL dis_am: got %0d expected 0", am); end
        checks++; if (pm !== 5'd0)      begin errors++; $display("[TB] FAIL dis_pm: got %0d expected 0", pm); end
        checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL dis_step: got %0b expected 0", lfo_step); end
        lfo_en = 1'b1;
        tick(4);
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL reen_cnt4: got %0d expected 0", lfo_cnt); end
        tick(1);
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL reen_cnt5: got %0d expected 1", lfo_cnt); end
        checks++; if (lfo_step !== 1'b1) begin errors++; $display("[TB] FAIL reen_step5: got %0b expected 1", lfo_step); end
    endtask

    // Continues from test_disable's final state: cnt=1, am=2, step=1
    task automatic test_clk_en_gating();
        clk_en = 1'b0;
        zero   = 1'b1;
        repeat (50) @(negedge clk);
        zero = 1'b0;
        checks++; if (lfo_cnt !== 7'd1) begin errors++; $display("[TB] FAIL gate_cnt: got %0d expected 1", lfo_cnt); end
        checks++; if (am !== 7'd2)      begin errors++; $display("[TB] FAIL gate_am: got %0d expected 2", am); end
        checks++; if (lfo_step !== 1'b1) begin errors++; $display("[TB] FAIL gate_step_hold: got %0b expected 1", lfo_step); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (lfo_cnt !== 7'd0) begin errors++; $display("[TB] FAIL gate_reset_cnt: got %0d expected 0", lfo_cnt); end
        checks++; if (lfo_step !== 1'b0) begin errors++; $display("[TB] FAIL gate_reset_step: got %0b expected 0", lfo_step); end
    endtask

`ifdef JT12_LFO_TEST_EN
    task automatic test_test_mode();
        do_reset();
        lfo_en   = 1'b1;
        lfo_freq = 3'd0;
        test_lfo = 1'b1;
        tick(10);
        checks++; if (lfo_cnt !== 7'd10) begin errors++; $display("[TB] FAIL test_mode_cnt: got %0d expected 10", lfo_cnt); end
        test_lfo = 1'b0;
        tick(107);
        checks++; if (lfo_cnt !== 7'd10) begin errors++; $display("[TB] FAIL test_mode_off107: got %0d expected 10", lfo_cnt); end
        tick(1);
        checks++; if (lfo_cnt !== 7'd11) begin errors++; $display("[TB] FAIL test_mode_off108: got %0d expected 11", lfo_cnt); end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        clk_en   = 1'b0;
        zero     = 1'b0;
        lfo_en   = 1'b0;
        lfo_freq = 3'd0;
`ifdef JT12_LFO_TEST_EN
        test_lfo = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_fastest();
        test_triangle();
        test_rate_change();
        test_disable();
        test_clk_en_gating();
`ifdef JT12_LFO_TEST_EN
        test_test_mode();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
